// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-equivalent counter family.
package ttl_pkg;

    // Boundary behaviour select
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the top-value helper supports
    localparam int MAX_W = 32;

    // Modulus -> highest reachable count. M == 0 selects the full 2^w range.
    function automatic logic [MAX_W-1:0] top_value(input logic [MAX_W-1:0] m, input int w);
        if (m == '0)
            return {MAX_W{1'b1}} >> (MAX_W - w);
        else
            return m - MAX_W'(1);
    endfunction

endpackage

// File: rtl/ttl_mod_updown_counter_if.sv
// Control/data bundle of the modulo up/down counter.
interface ttl_mod_updown_counter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SR_n;
    logic                  PE_n;
    logic                  U_D;
    logic                  CEP_n;
    logic                  CET_n;
    logic [DATA_WIDTH-1:0] P;
    logic [DATA_WIDTH-1:0] M;
    logic [DATA_WIDTH-1:0] Q;
    logic                  TC_n;
    logic                  WRAP;

    modport master (
        output SR_n, PE_n, U_D, CEP_n, CET_n, P, M,
        input  Q, TC_n, WRAP
    );

    modport slave (
        input  SR_n, PE_n, U_D, CEP_n, CET_n, P, M,
        output Q, TC_n, WRAP
    );
endinterface

// File: rtl/ttl_mod_next.sv
// Combinational next-count logic: one step up or down against the modulus,
// either wrapping or saturating at the boundary.
module ttl_mod_next
    import ttl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] m,
    input  logic                  u_d,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] q_next,
    output logic                  wrap,
    output logic                  at_term
);

    logic [DATA_WIDTH-1:0] top;

    assign top = DATA_WIDTH'(top_value(MAX_W'(m), DATA_WIDTH));

    // Step one count; values above TOP (out-of-range load or shrunk M) recover to TOP
    always_comb begin
        q_next  = q;
        wrap    = 1'b0;
        at_term = 1'b0;
        if (u_d) begin
            at_term = (q >= top);
            if (q >= top) begin
                if (sat == MODE_SAT) begin
                    q_next = top;
                end else begin
                    q_next = '0;
                    wrap   = 1'b1;
                end
            end else begin
                q_next = q + DATA_WIDTH'(1);
            end
        end else begin
            at_term = (q == '0);
            if (q == '0) begin
                if (sat != MODE_SAT) begin
                    q_next = top;
                    wrap   = 1'b1;
                end
            end else if (q > top) begin
                q_next = top;
            end else begin
                q_next = q - DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ttl_mod_updown_counter.sv
// Programmable-modulus synchronous up/down counter with clear, load,
// cascadable terminal count and registered wrap pulse.
module ttl_mod_updown_counter
    import ttl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ttl_mod_updown_counter_if.slave bus
);

    localparam logic SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [DATA_WIDTH-1:0] q_r;
    logic [DATA_WIDTH-1:0] q_next;
    logic                  wrap_r;
    logic                  cnt_wrap;
    logic                  at_term;
    logic                  en;

    ttl_mod_next #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next (
        .q       (q_r),
        .m       (bus.M),
        .u_d     (bus.U_D),
        .sat     (SAT_MODE),
        .q_next  (q_next),
        .wrap    (cnt_wrap),
        .at_term (at_term)
    );

    assign en = !bus.CEP_n && !bus.CET_n;

    // Count register: reset > clear > load > count > hold; WRAP only on a counted wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r    <= DATA_WIDTH'(RESET_VALUE);
            wrap_r <= 1'b0;
        end else if (!bus.SR_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else if (!bus.PE_n) begin
            q_r    <= bus.P;
            wrap_r <= 1'b0;
        end else if (en) begin
            q_r    <= q_next;
            wrap_r <= cnt_wrap;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign bus.Q    = q_r;
    assign bus.WRAP = wrap_r;
    // Only CET_n gates TC_n so a stage's TC_n can feed the next stage's CET_n
    assign bus.TC_n = !(!bus.CET_n && at_term);

endmodule

// File: tb/tb_ttl_mod_updown_counter.sv
// Directed bench: wrap-mode and saturate-mode 8-bit counters driven from a
// shared vector table, plus reset and two-stage cascade sequences.
module tb_ttl_mod_updown_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ttl_mod_updown_counter_if #(.DATA_WIDTH(8)) bw ();
    ttl_mod_updown_counter_if #(.DATA_WIDTH(8)) bs ();
    ttl_mod_updown_counter_if #(.DATA_WIDTH(4)) bc0 ();
    ttl_mod_updown_counter_if #(.DATA_WIDTH(4)) bc1 ();

    ttl_mod_updown_counter #(.DATA_WIDTH(8), .SATURATE(0), .RESET_VALUE(5))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
    ttl_mod_updown_counter #(.DATA_WIDTH(8), .SATURATE(1), .RESET_VALUE(0))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    ttl_mod_updown_counter #(.DATA_WIDTH(4), .SATURATE(0), .RESET_VALUE(0))
        dut_c0 (.clk(clk), .rst_n(rst_n), .bus(bc0));
    ttl_mod_updown_counter #(.DATA_WIDTH(4), .SATURATE(0), .RESET_VALUE(0))
        dut_c1 (.clk(clk), .rst_n(rst_n), .bus(bc1));

    // Stage 0 terminal count enables stage 1
    assign bc1.CET_n = bc0.TC_n;

    typedef struct {
        logic       sel;     // 0 = wrap counter, 1 = saturating counter
        logic       sr_n, pe_n, u_d, cep_n, cet_n;
        logic [7:0] p, m;
        logic [7:0] q;
        logic       wrap, tc_n;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic sel, logic sr_n, logic pe_n, logic u_d,
                                logic cep_n, logic cet_n, logic [7:0] p,
                                logic [7:0] m, logic [7:0] q, logic wrap, logic tc_n);
        vec_t v;
        v.sel = sel; v.sr_n = sr_n; v.pe_n = pe_n; v.u_d = u_d;
        v.cep_n = cep_n; v.cet_n = cet_n; v.p = p; v.m = m;
        v.q = q; v.wrap = wrap; v.tc_n = tc_n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bw.SR_n = v.sr_n; bw.PE_n = v.pe_n; bw.U_D = v.u_d;
        bw.CEP_n = v.cep_n; bw.CET_n = v.cet_n; bw.P = v.p; bw.M = v.m;
        bs.SR_n = v.sr_n; bs.PE_n = v.pe_n; bs.U_D = v.u_d;
        bs.CEP_n = v.cep_n; bs.CET_n = v.cet_n; bs.P = v.p; bs.M = v.m;
    endtask

    task automatic set_casc(input logic pe_n, input logic cep_n, input logic cet0_n,
                            input logic [3:0] p0, input logic [3:0] p1);
        bc0.SR_n = 1'b1; bc0.PE_n = pe_n; bc0.U_D = 1'b1; bc0.CEP_n = cep_n;
        bc0.CET_n = cet0_n; bc0.P = p0; bc0.M = 4'd0;
        bc1.SR_n = 1'b1; bc1.PE_n = pe_n; bc1.U_D = 1'b1; bc1.CEP_n = cep_n;
        bc1.P = p1; bc1.M = 4'd0;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // wrap counter, M=10: hold after reset, clear, count 1..9
        vq.push_back(mk(0, 1,1,1,1,0, 8'd0,   8'd10, 8'd5,   0, 1));
        vq.push_back(mk(0, 0,1,1,0,0, 8'd0,   8'd10, 8'd0,   0, 1));
        for (int k = 1; k <= 9; k++)
            vq.push_back(mk(0, 1,1,1,0,0, 8'd0, 8'd10, 8'(k), 0, (k == 9) ? 1'b0 : 1'b1));
        // CEP_n high holds but does not gate TC_n
        vq.push_back(mk(0, 1,1,1,1,0, 8'd0,   8'd10, 8'd9,   0, 0));
        vq.push_back(mk(0, 1,1,1,0,0, 8'd0,   8'd10, 8'd0,   1, 1));
        vq.push_back(mk(0, 1,1,1,0,0, 8'd0,   8'd10, 8'd1,   0, 1));
        // down wrap from 2
        vq.push_back(mk(0, 1,0,0,1,1, 8'd2,   8'd10, 8'd2,   0, 1));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd10, 8'd1,   0, 1));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd10, 8'd0,   0, 0));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd10, 8'd9,   1, 1));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd10, 8'd8,   0, 1));
        // clear beats load; out-of-range load kept; recovery up and down
        vq.push_back(mk(0, 0,0,1,0,0, 8'd7,   8'd10, 8'd0,   0, 1));
        vq.push_back(mk(0, 1,0,1,0,0, 8'd200, 8'd10, 8'd200, 0, 0));
        vq.push_back(mk(0, 1,1,1,0,0, 8'd0,   8'd10, 8'd0,   1, 1));
        vq.push_back(mk(0, 1,0,0,0,0, 8'd200, 8'd10, 8'd200, 0, 1));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd10, 8'd9,   0, 1));
        // M=0 full binary range
        vq.push_back(mk(0, 1,0,1,0,0, 8'd254, 8'd0,  8'd254, 0, 1));
        vq.push_back(mk(0, 1,1,1,0,0, 8'd0,   8'd0,  8'd255, 0, 0));
        vq.push_back(mk(0, 1,1,1,0,0, 8'd0,   8'd0,  8'd0,   1, 1));
        vq.push_back(mk(0, 1,1,0,0,0, 8'd0,   8'd0,  8'd255, 1, 1));
        // CET_n high alone holds and forces TC_n high
        vq.push_back(mk(0, 1,1,0,0,1, 8'd0,   8'd0,  8'd255, 0, 1));
        // saturating counter, M=4
        vq.push_back(mk(1, 1,0,1,1,0, 8'd2,   8'd4,  8'd2,   0, 1));
        vq.push_back(mk(1, 1,1,1,0,0, 8'd0,   8'd4,  8'd3,   0, 0));
        vq.push_back(mk(1, 1,1,1,0,0, 8'd0,   8'd4,  8'd3,   0, 0));
        vq.push_back(mk(1, 1,1,1,0,0, 8'd0,   8'd4,  8'd3,   0, 0));
        vq.push_back(mk(1, 1,1,0,0,0, 8'd0,   8'd4,  8'd2,   0, 1));
        vq.push_back(mk(1, 1,1,0,0,0, 8'd0,   8'd4,  8'd1,   0, 1));
        vq.push_back(mk(1, 1,1,0,0,0, 8'd0,   8'd4,  8'd0,   0, 0));
        vq.push_back(mk(1, 1,1,0,0,0, 8'd0,   8'd4,  8'd0,   0, 0));
        vq.push_back(mk(1, 1,0,0,1,1, 8'd9,   8'd4,  8'd9,   0, 1));
        vq.push_back(mk(1, 1,1,0,0,0, 8'd0,   8'd4,  8'd3,   0, 1));
        vq.push_back(mk(1, 1,0,1,0,0, 8'd255, 8'd0,  8'd255, 0, 0));
        vq.push_back(mk(1, 1,1,1,0,0, 8'd0,   8'd0,  8'd255, 0, 0));

        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        set_casc(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
        for (int r = 0; r < 2; r++) begin
            bw.SR_n = 1'($urandom); bw.PE_n = 1'($urandom); bw.U_D = 1'($urandom);
            bw.CEP_n = 1'($urandom); bw.CET_n = 1'($urandom);
            bw.P = 8'($urandom); bw.M = 8'($urandom);
            bs.SR_n = 1'($urandom); bs.PE_n = 1'($urandom); bs.U_D = 1'($urandom);
            bs.CEP_n = 1'($urandom); bs.CET_n = 1'($urandom);
            bs.P = 8'($urandom); bs.M = 8'($urandom);
            tick();
            check($sformatf("reset%0d q", r), 32'(bw.Q), 32'd5);
            check($sformatf("reset%0d wrap", r), 32'(bw.WRAP), 32'd0);
            check($sformatf("reset%0d sat q", r), 32'(bs.Q), 32'd0);
        end
        rst_n = 1'b1;

        // ---------------- table ----------------
        foreach (vq[i]) begin
            drive(vq[i]);
            tick();
            if (vq[i].sel == 1'b0) begin
                check($sformatf("v%0d q", i),    32'(bw.Q),    32'(vq[i].q));
                check($sformatf("v%0d wrap", i), 32'(bw.WRAP), 32'(vq[i].wrap));
                check($sformatf("v%0d tc_n", i), 32'(bw.TC_n), 32'(vq[i].tc_n));
            end else begin
                check($sformatf("v%0d sat q", i),    32'(bs.Q),    32'(vq[i].q));
                check($sformatf("v%0d sat wrap", i), 32'(bs.WRAP), 32'(vq[i].wrap));
                check($sformatf("v%0d sat tc_n", i), 32'(bs.TC_n), 32'(vq[i].tc_n));
            end
        end

        // ---------------- reset mid-count ----------------
        drive(mk(0, 1,0,1,0,0, 8'd8, 8'd10, 8'd0, 0, 0));
        tick();
        drive(mk(0, 1,1,1,0,0, 8'd0, 8'd10, 8'd0, 0, 0));
        tick();
        check("pre-reset q", 32'(bw.Q), 32'd9);
        rst_n = 1'b0;
        tick();
        check("midreset q", 32'(bw.Q), 32'd5);
        check("midreset wrap", 32'(bw.WRAP), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset count q", 32'(bw.Q), 32'd6);

        // ---------------- two-stage cascade ----------------
        set_casc(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        tick();
        check("casc load", 32'({bc1.Q, bc0.Q}), 32'h0F);
        check("casc tc0 at F", 32'(bc0.TC_n), 32'd0);
        check("casc tc1", 32'(bc1.TC_n), 32'd1);
        set_casc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("casc carry", 32'({bc1.Q, bc0.Q}), 32'h10);
        set_casc(1'b0, 1'b1, 1'b1, 4'hF, 4'h1);
        tick();
        check("casc load2", 32'({bc1.Q, bc0.Q}), 32'h1F);
        check("casc tc0 gated", 32'(bc0.TC_n), 32'd1);
        set_casc(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        tick();
        check("casc hold", 32'({bc1.Q, bc0.Q}), 32'h1F);
        set_casc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("casc carry2", 32'({bc1.Q, bc0.Q}), 32'h20);
        check("casc wrap0", 32'(bc0.WRAP), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ttl_mod_updown_counter.md
Name: ttl_mod_updown_counter

Overview:
- Parameterised synchronous up/down counter in the TTL-equivalent library; the next generation after the fixed binary 8-bit up/down counter.
- Adds a runtime-programmable modulus, a wrap/saturate mode, synchronous clear, a CET-gated cascade terminal count and a registered wrap pulse.
- Used for divide-by-N timers, address sequencers and multi-stage cascaded counters.

Parameters:
- DATA_WIDTH, 8, counter width in bits; must be >= 2.
- SATURATE, 0, 0 = wrap at the modulus boundary; 1 = hold at the boundary.
- RESET_VALUE, 0, value loaded into Q on reset; must be < 2^DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- SR_n  input  1  synchronous clear to 0 when low.
- PE_n  input  1  synchronous parallel load when low.
- U_D  input  1  direction: 1 = up, 0 = down.
- CEP_n  input  1  count enable (parallel), active low.
- CET_n  input  1  count enable (trickle), active low; also gates TC_n.
- P  input  DATA_WIDTH  parallel load data.
- M  input  DATA_WIDTH  modulus; 0 means full range 2^DATA_WIDTH.
- Q  output  DATA_WIDTH  counter value (registered).
- TC_n  output  1  terminal count, active low, combinational.
- WRAP  output  1  one-cycle registered pulse on a boundary crossing.

Behaviour:
- Reset:
  - rst_n low at a clk edge: Q <= RESET_VALUE and WRAP <= 0.
  - Reset overrides all other inputs. Reset mid-count takes effect on that edge; there is no residual state.
- Priority per edge: rst_n > SR_n > PE_n > count > hold.
- SR_n low: Q <= 0, WRAP <= 0.
- PE_n low: Q <= P, WRAP <= 0. P >= M is loaded unchanged (no clamping).
- Count enable: en = !CEP_n && !CET_n. If en is low, Q holds and WRAP <= 0.
- Effective top value: TOP = M-1 when M != 0, else all-ones.
- Up count, SATURATE=0: Q >= TOP -> Q <= 0 with WRAP <= 1; otherwise Q+1.
- Up count, SATURATE=1: Q >= TOP -> Q <= TOP, WRAP <= 0.
- Down count, SATURATE=0:
  - Q == 0 -> Q <= TOP with WRAP <= 1.
  - Q > TOP -> Q <= TOP with WRAP <= 0.
  - Otherwise Q-1.
- Down count, SATURATE=1: Q == 0 holds 0; Q > TOP -> Q <= TOP; otherwise Q-1. WRAP is always 0 in saturate mode.
- TC_n:
  - Low when CET_n is low and either (U_D=1 and Q >= TOP) or (U_D=0 and Q == 0).
  - CEP_n does not gate TC_n, so stages cascade by wiring TC_n to the next stage's CET_n.
- Direction change (U_D toggles) takes effect on the same edge; there is no pipeline.
- M changes at any time; the new TOP applies at the next edge. Q > new TOP recovers per the rules above.
- Latency: one clock from inputs to Q and WRAP; TC_n follows Q and inputs combinationally.
- Width rules:
  - All arithmetic is DATA_WIDTH bits, modulo 2^DATA_WIDTH.
  - TOP is computed as M - 1 in DATA_WIDTH bits with M=0 special-cased, so no extra carry bit.
- Mode 2^W (M=0): behaviour is identical to a plain binary up/down counter.

Decomposition:
- Shared package ttl_pkg: wrap/saturate mode constants (MODE_WRAP=0, MODE_SAT=1) and a top-value function (M -> TOP).
- One combinational sub-module, ttl_mod_next:
  - Inputs: Q, M, U_D, SATURATE.
  - Outputs: next count, wrap flag, at-terminal flag.
  - The top level holds the register, priority muxing and TC_n gating.

Test Plan:
- Reset: rst_n=0 for 2 edges with RESET_VALUE=5, other inputs random -> Q=5, WRAP=0; release, hold CEP_n=1 -> Q stays 5.
- Modulo-10 up wrap: M=10, U_D=1, enables low from Q=0 -> Q 0..9 then 0. WRAP=1 for exactly the cycle after 9->0. TC_n=0 while Q=9.
- Modulo-10 down wrap: M=10, U_D=0 from Q=2 -> 1, 0, 9, 8. WRAP pulses once after 0->9. TC_n=0 while Q=0.
- Saturate: SATURATE=1, M=4, up from Q=2 -> 3, 3, 3 with WRAP=0 throughout. Switch U_D=0 -> 2, 1, 0, 0.
- Priority and out-of-range load: SR_n=0 and PE_n=0 on the same edge with P=7 -> Q=0. Next edge, PE_n=0 with P=200, M=10 -> Q=200. Then count up -> Q=0 with WRAP=1; separately, count down from 200 -> Q=9.
- Cascade: two 4-bit instances, M=0, stage0 TC_n driving stage1 CET_n, up from 0x0F -> 0x10 on one edge. CET_n=1 on stage0 forces TC_n=1 and holds both stages.
